// File: rtl/parking_gate_controller.sv
// Parking-lot entry gate controller: occupancy counter with saturation and sticky
// error, plus a three-state entry gate FSM with an open-time limit.
module parking_gate_controller #(
    parameter int CAPACITY     = 8,
    parameter int CNT_W        = 4,
    parameter int GATE_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             car_enter,
    input  logic             car_exit,
    input  logic             entry_req,
    output logic             gate_open,
    output logic             lot_full,
    output logic [CNT_W-1:0] occupancy,
    output logic [CNT_W-1:0] free_spaces,
    output logic             error
);

    localparam int TMR_W = $clog2(GATE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CAP_C     = CNT_W'(CAPACITY);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(GATE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPEN  = 2'd1,
        ST_CLOSE = 2'd2
    } gate_state_t;

    gate_state_t      r_state;
    gate_state_t      w_next_state;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;
    logic             r_gate_open;
    logic             w_gate_open_nxt;
    logic [CNT_W-1:0] r_occupancy;
    logic [CNT_W-1:0] w_occupancy_nxt;
    logic             r_error;
    logic             w_error_nxt;
    logic             w_lot_full;

    // Full/free status comes only from the registered count.
    assign w_lot_full  = (r_occupancy == CAP_C);
    assign lot_full    = w_lot_full;
    assign free_spaces = CAP_C - r_occupancy;
    assign occupancy   = r_occupancy;
    assign error       = r_error;
    assign gate_open   = r_gate_open;

    // Gate FSM state register, open timer and registered gate output.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_timer     <= {TMR_W{1'b0}};
            r_gate_open <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_timer     <= w_timer_nxt;
            r_gate_open <= w_gate_open_nxt;
        end
    end

    // Gate FSM next-state logic; car_enter outranks the timeout.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (entry_req && !w_lot_full) begin
                    w_next_state = ST_OPEN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_OPEN: begin
                if (car_enter || (r_timer == TMR_LAST)) begin
                    w_next_state = ST_CLOSE;
                end else begin
                    w_next_state = ST_OPEN;
                end
            end
            ST_CLOSE: w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Gate FSM outputs: timer restarts at 0 on each entry into OPEN.
    always_comb begin
        w_gate_open_nxt = (w_next_state == ST_OPEN);
        if ((r_state == ST_OPEN) && (w_next_state == ST_OPEN)) begin
            w_timer_nxt = r_timer + TMR_W'(1);
        end else begin
            w_timer_nxt = {TMR_W{1'b0}};
        end
    end

    // Occupancy next value with saturation and sticky error.
    always_comb begin
        w_occupancy_nxt = r_occupancy;
        w_error_nxt     = r_error;
        if (car_enter && !car_exit) begin
            if (w_lot_full) begin
                w_error_nxt = 1'b1;
            end else begin
                w_occupancy_nxt = r_occupancy + CNT_W'(1);
            end
        end else if (car_exit && !car_enter) begin
            if (r_occupancy == {CNT_W{1'b0}}) begin
                w_error_nxt = 1'b1;
            end else begin
                w_occupancy_nxt = r_occupancy - CNT_W'(1);
            end
        end else begin
            w_occupancy_nxt = r_occupancy;
        end
    end

    // Occupancy and error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_occupancy <= {CNT_W{1'b0}};
            r_error     <= 1'b0;
        end else begin
            r_occupancy <= w_occupancy_nxt;
            r_error     <= w_error_nxt;
        end
    end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Self-checking bench for parking_gate_controller: directed scenarios plus a
// randomized run against a behavioural model of lot and gate.
module tb_parking_gate_controller;

    localparam int CAP = 8;
    localparam int CW  = 4;
    localparam int GT  = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          car_enter = 1'b0;
    logic          car_exit = 1'b0;
    logic          entry_req = 1'b0;
    logic          gate_open;
    logic          lot_full;
    logic [CW-1:0] occupancy;
    logic [CW-1:0] free_spaces;
    logic          error;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: car count, sticky error, cycles the gate has been up (0 = down),
    // and a flag for the single cool-down cycle after the gate drops.
    int m_occ     = 0;
    bit m_err     = 1'b0;
    int m_age     = 0;
    bit m_closing = 1'b0;

    parking_gate_controller #(
        .CAPACITY(CAP), .CNT_W(CW), .GATE_TIMEOUT(GT)
    ) dut (
        .clk(clk), .reset(reset), .car_enter(car_enter), .car_exit(car_exit),
        .entry_req(entry_req), .gate_open(gate_open), .lot_full(lot_full),
        .occupancy(occupancy), .free_spaces(free_spaces), .error(error)
    );

    always #5 clk = ~clk;

    task automatic step(input bit rst, input bit en, input bit ex, input bit rq);
        bit was_full;
        reset = rst; car_enter = en; car_exit = ex; entry_req = rq;
        @(posedge clk);
        was_full = (m_occ == CAP);
        if (rst) begin
            m_occ = 0; m_err = 1'b0; m_age = 0; m_closing = 1'b0;
        end else begin
            if (en && !ex) begin
                if (m_occ == CAP) m_err = 1'b1; else m_occ++;
            end else if (ex && !en) begin
                if (m_occ == 0) m_err = 1'b1; else m_occ--;
            end
            if (m_closing) begin
                m_closing = 1'b0;
            end else if (m_age > 0) begin
                if (en || m_age == GT) begin
                    m_age = 0; m_closing = 1'b1;
                end else begin
                    m_age++;
                end
            end else if (rq && !was_full) begin
                m_age = 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        step(1, 1, 0, 1);
        n_checks++; if (gate_open !== 1'b0) begin n_fail++; $display("FAIL reset_gate got=%b exp=0", gate_open); end
        n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", error); end
        n_checks++; if (free_spaces !== 4'd8) begin n_fail++; $display("FAIL reset_free got=%0d exp=8", free_spaces); end
        n_checks++; if (lot_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", lot_full); end
        step(0, 0, 0, 1);
        n_checks++; if (gate_open !== 1'b1) begin n_fail++; $display("FAIL release_open got=%b exp=1", gate_open); end
        step(1, 0, 0, 0);
    endtask

    task automatic test_gate_basic();
        int hi;
        step(1, 0, 0, 0);
        hi = 0;
        step(0, 0, 0, 1); hi += int'(gate_open);
        step(0, 0, 0, 0); hi += int'(gate_open);
        step(0, 0, 0, 0); hi += int'(gate_open);
        step(0, 1, 0, 0); hi += int'(gate_open);
        step(0, 0, 0, 0); hi += int'(gate_open);
        n_checks++; if (hi != 3) begin n_fail++; $display("FAIL basic_open_cycles got=%0d exp=3", hi); end
        n_checks++; if (occupancy !== 4'd1) begin n_fail++; $display("FAIL basic_occ got=%0d exp=1", occupancy); end
        n_checks++; if (free_spaces !== 4'd7) begin n_fail++; $display("FAIL basic_free got=%0d exp=7", free_spaces); end
    endtask

    task automatic test_timeout();
        int run, first_low, reopen;
        step(1, 0, 0, 0);
        run = 0; first_low = 0; reopen = 0;
        for (int i = 1; i <= 30; i++) begin
            step(0, 0, 0, 1);
            if (first_low == 0) begin
                if (gate_open) run++; else first_low = i;
            end else if (gate_open && reopen == 0) begin
                reopen = i;
            end
        end
        n_checks++; if (run != GT) begin n_fail++; $display("FAIL timeout_high got=%0d exp=%0d", run, GT); end
        n_checks++; if (first_low != GT + 1) begin n_fail++; $display("FAIL timeout_close_at got=%0d exp=%0d", first_low, GT + 1); end
        n_checks++; if (reopen != GT + 3) begin n_fail++; $display("FAIL timeout_reopen_at got=%0d exp=%0d", reopen, GT + 3); end
        n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL timeout_occ got=%0d exp=0", occupancy); end
    endtask

    task automatic test_full();
        int hi;
        step(1, 0, 0, 0);
        for (int i = 0; i < CAP; i++) step(0, 1, 0, 0);
        n_checks++; if (occupancy !== 4'd8) begin n_fail++; $display("FAIL full_occ got=%0d exp=8", occupancy); end
        n_checks++; if (lot_full !== 1'b1) begin n_fail++; $display("FAIL full_flag got=%b exp=1", lot_full); end
        n_checks++; if (free_spaces !== 4'd0) begin n_fail++; $display("FAIL full_free got=%0d exp=0", free_spaces); end
        hi = 0;
        for (int i = 0; i < 3; i++) begin step(0, 0, 0, 1); hi += int'(gate_open); end
        n_checks++; if (hi != 0) begin n_fail++; $display("FAIL full_gate_ignored got=%0d exp=0", hi); end
        step(0, 0, 1, 1);
        n_checks++; if (lot_full !== 1'b0) begin n_fail++; $display("FAIL exit_unfull got=%b exp=0", lot_full); end
        n_checks++; if (gate_open !== 1'b0) begin n_fail++; $display("FAIL exit_gate got=%b exp=0", gate_open); end
        step(0, 0, 0, 1);
        n_checks++; if (gate_open !== 1'b1) begin n_fail++; $display("FAIL after_exit_open got=%b exp=1", gate_open); end
    endtask

    task automatic test_saturate();
        step(1, 0, 0, 0);
        for (int i = 0; i < CAP; i++) step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        n_checks++; if (occupancy !== 4'd8) begin n_fail++; $display("FAIL both_at_full_occ got=%0d exp=8", occupancy); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL both_at_full_err got=%b exp=0", error); end
        step(0, 1, 0, 0);
        n_checks++; if (occupancy !== 4'd8) begin n_fail++; $display("FAIL overflow_occ got=%0d exp=8", occupancy); end
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL overflow_err got=%b exp=1", error); end
        step(0, 1, 1, 0);
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL err_sticky got=%b exp=1", error); end
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL underflow_occ got=%0d exp=0", occupancy); end
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL underflow_err got=%b exp=1", error); end
    endtask

    task automatic test_reset_mid_open();
        step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        n_checks++; if (gate_open !== 1'b1 || occupancy !== 4'd5 || error !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_state got=%b/%0d/%b exp=1/5/1", gate_open, occupancy, error);
        end
        step(1, 1, 0, 1);
        n_checks++; if (gate_open !== 1'b0) begin n_fail++; $display("FAIL midreset_gate got=%b exp=0", gate_open); end
        n_checks++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL midreset_occ got=%0d exp=0", occupancy); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL midreset_err got=%b exp=0", error); end
        step(0, 0, 0, 1);
        n_checks++; if (gate_open !== 1'b1) begin n_fail++; $display("FAIL midreset_idle_reopen got=%b exp=1", gate_open); end
    endtask

    task automatic test_random();
        bit rst, en, ex, rq;
        step(1, 0, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            en  = ($urandom_range(0, 2) == 0);
            ex  = ($urandom_range(0, 3) == 0);
            rq  = ($urandom_range(0, 1) == 0);
            step(rst, en, ex, rq);
            n_checks++; if (gate_open !== (m_age > 0)) begin n_fail++; $display("FAIL rnd_gate step=%0d got=%b exp=%b", i, gate_open, (m_age > 0)); end
            n_checks++; if (occupancy !== CW'(m_occ)) begin n_fail++; $display("FAIL rnd_occ step=%0d got=%0d exp=%0d", i, occupancy, m_occ); end
            n_checks++; if (free_spaces !== CW'(CAP - m_occ)) begin n_fail++; $display("FAIL rnd_free step=%0d got=%0d exp=%0d", i, free_spaces, CAP - m_occ); end
            n_checks++; if (lot_full !== (m_occ == CAP)) begin n_fail++; $display("FAIL rnd_full step=%0d got=%b exp=%b", i, lot_full, (m_occ == CAP)); end
            n_checks++; if (error !== m_err) begin n_fail++; $display("FAIL rnd_err step=%0d got=%b exp=%b", i, error, m_err); end
        end
    endtask

    initial begin
        test_reset();
        test_gate_basic();
        test_timeout();
        test_full();
        test_saturate();
        test_reset_mid_open();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
